multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multi-cycle control FSM for the RV32I core datapath (shared ALU, single memory port, SignExtend).
//  Sequences fetch/decode/execute/writeback and drives imm_src into SignExtend, ALU mux selects,
//  register-file and memory strobes. Supports lw, sw, R-type ALU, I-type ALU, beq.
//  Memory port uses a req/ready handshake, so any wait-state count is tolerated.
// PARAMETERS
//  none (all encodings are fixed constants in riscv_ctrl_pkg)
// PORTS
//  clk            in   1  system clock, all state on rising edge
//  rst_n          in   1  asynchronous, active-low reset
//  op             in   7  instr[6:0] from instruction register
//  funct3         in   3  instr[14:12]
//  funct7b5       in   1  instr[30]
//  zero           in   1  ALU zero flag
//  mem_ready      in   1  memory completes current access this cycle
//  mem_req        out  1  memory access request, held until mem_ready
//  mem_write      out  1  request is a store (valid only with mem_req)
//  adr_src        out  1  0 = PC, 1 = ALUOut drives memory address
//  ir_write       out  1  load instruction register and OldPC
//  pc_write       out  1  load PC from result bus
//  reg_write      out  1  register-file write enable
//  imm_src        out  2  SignExtend select: 00 I, 01 S, 10 B
//  alu_src_a      out  2  00 PC, 01 OldPC, 10 rs1 (A reg)
//  alu_src_b      out  2  00 rs2 (WriteData reg), 01 ImmExt, 10 const 4
//  result_src     out  2  00 ALUOut, 01 Data reg, 10 ALU result direct
//  alu_control    out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  illegal_instr  out  1  sticky flag, unsupported encoding decoded
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; every strobe (mem_req, mem_write, ir_write, pc_write,
//    reg_write) = 0; illegal_instr = 0; selects = 0. IDLE -> FETCH unconditionally next cycle.
//  - Outputs are Moore-decoded from state, except pc_write in FETCH (= mem_ready) and BEQ (= zero),
//    and ir_write in FETCH (= mem_ready). Unlisted outputs are 0 in each state.
//  - FETCH: mem_req=1, adr_src=0, src_a=00, src_b=10, add, result_src=10. Stay while !mem_ready;
//    on mem_ready: ir_write=1, pc_write=1 (PC+4), -> DECODE.
//  - DECODE: src_a=01, src_b=01, imm_src=10, add (branch target into ALUOut). Next:
//    0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI;
//    1100011 with funct3=000 -> BEQ; anything else -> TRAP.
//  - MEMADR: src_a=10, src_b=01, add, imm_src=00 if op=lw else 01; -> MEMREAD (lw) / MEMWRITE (sw).
//  - MEMREAD: mem_req=1, adr_src=1; wait on mem_ready -> MEMWB.
//  - MEMWB: result_src=01, reg_write=1 -> FETCH.
//  - MEMWRITE: mem_req=1, mem_write=1, adr_src=1; wait on mem_ready -> FETCH. Store commits in mem_ready cycle.
//  - EXECR: src_a=10, src_b=00, ALU-decode; EXECI: src_a=10, src_b=01, imm_src=00, ALU-decode; both -> ALUWB.
//  - ALUWB: result_src=00, reg_write=1 -> FETCH.
//  - BEQ: src_a=10, src_b=00, sub, result_src=00, pc_write=zero -> FETCH.
//  - TRAP: illegal_instr set and held; no strobes; remain in TRAP until reset.
//  - ALU decode (EXECR/EXECI): funct3 000 -> add, or sub iff R-type and funct7b5=1; 010 -> slt;
//    110 -> or; 111 -> and; any other funct3 -> TRAP from DECODE (checked there, not in EXEC).
//  - Handshake: mem_req, mem_write, adr_src stable from first req cycle through mem_ready cycle;
//    mem_ready while mem_req=0 is ignored. Zero-wait memory (mem_ready same cycle) is legal.
//  - Latency (zero-wait): lw 5, sw 4, R/I 4, beq 3 cycles.
//  - Reset mid-access: mem_req drops asynchronously; no partial strobe after rst_n falls.
// STRUCTURE
//  - riscv_ctrl_pkg: state encoding (IDLE..TRAP, 4 bits), opcode constants, imm_src, alu_control,
//    src_a/src_b/result_src encodings, ALUOp (00 add, 01 sub, 10 funct-decode).
//  - Sub-module alu_decoder (combinational: ALUOp, funct3, funct7b5, op[5] -> alu_control).
//  - Main FSM: one state register, next-state block, output-decode block.
// TESTING
//  - Reset: rst_n=0 -> all strobes 0, illegal_instr 0; release -> IDLE, then FETCH with mem_req=1.
//  - lw (0x0000A083), mem_ready low 2 cycles each access -> FETCH 3 cyc, MEMREAD 3 cyc, imm_src=00
//    in MEMADR, one reg_write pulse with result_src=01; total 9 cycles.
//  - sw (0x0020A023), zero-wait -> imm_src=01 in MEMADR, single mem_write+mem_req cycle, no reg_write.
//  - R-type sub (0x40208033) -> alu_control=001 in EXECR; add (0x00208033) -> 000; reg_write in ALUWB.
//  - beq (0x00208063): zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0; both return to FETCH.
//  - Illegal op 0x0000007F -> TRAP, illegal_instr=1 held 20 cycles; rst_n pulse low mid-MEMREAD
//    -> mem_req=0 immediately, flag cleared, restart from IDLE.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: FSM states, opcodes and datapath select codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMREAD  = 4'd4,
        MEMWB    = 4'd5,
        MEMWRITE = 4'd6,
        EXECR    = 4'd7,
        EXECI    = 4'd8,
        ALUWB    = 4'd9,
        BEQ      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Only these funct3 values have an ALU operation; anything else traps at decode.
    function automatic logic funct3Legal(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from ALUOp and the instruction function fields.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] aluOp,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       opB5,
    output logic [2:0] aluControl
);

    always_comb begin
        aluControl = ALU_ADD;
        case (aluOp)
            ALUOP_ADD: aluControl = ALU_ADD;
            ALUOP_SUB: aluControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op[5] separates R-type from I-type: addi never subtracts.
                    3'b000:  aluControl = (opB5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  aluControl = ALU_SLT;
                    3'b110:  aluControl = ALU_OR;
                    3'b111:  aluControl = ALU_AND;
                    default: aluControl = ALU_ADD;
                endcase
            end
            default: aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/writeback over a shared ALU
// and a single req/ready memory port.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] imm_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] alu_control,
    output logic       illegal_instr
);

    state_t     state;
    state_t     nextState;
    logic [1:0] aluOp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:   nextState = FETCH;
            FETCH:  nextState = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_RTYPE:     nextState = funct3Legal(funct3) ? EXECR : TRAP;
                    OP_ITYPE:     nextState = funct3Legal(funct3) ? EXECI : TRAP;
                    OP_BRANCH:    nextState = (funct3 == 3'b000) ? BEQ : TRAP;
                    default:      nextState = TRAP;
                endcase
            end
            MEMADR:   nextState = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  nextState = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    nextState = FETCH;
            MEMWRITE: nextState = mem_ready ? FETCH : MEMWRITE;
            EXECR, EXECI: nextState = ALUWB;
            ALUWB:    nextState = FETCH;
            BEQ:      nextState = FETCH;
            TRAP:     nextState = TRAP;
            default:  nextState = IDLE;
        endcase
    end

    // Outputs depend on state only, apart from the FETCH/BEQ strobes that follow mem_ready/zero.
    always_comb begin
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        imm_src       = IMM_I;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        result_src    = RES_ALUOUT;
        aluOp         = ALUOP_ADD;
        illegal_instr = 1'b0;
        case (state)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_B;
            end
            MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = (op == OP_LW) ? IMM_I : IMM_S;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                aluOp     = ALUOP_FUNCT;
            end
            EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_I;
                aluOp     = ALUOP_FUNCT;
            end
            ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
            end
            BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                aluOp      = ALUOP_SUB;
                result_src = RES_ALUOUT;
                pc_write   = zero;
            end
            TRAP:    illegal_instr = 1'b1;
            default: ;
        endcase
    end

    alu_decoder uAluDecoder (
        .aluOp      (aluOp),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .opB5       (op[5]),
        .aluControl (alu_control)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: a per-instruction phase model produces expected per-cycle outputs.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal_instr;
    logic [1:0] imm_src, alu_src_a, alu_src_b, result_src;
    logic [2:0] alu_control;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          ready;
        bit          zro;
        logic [17:0] exp;
        string       tag;
    } step_t;

    step_t stepQ[$];

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .imm_src(imm_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .alu_control(alu_control), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] observed();
        return {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                imm_src, alu_src_a, alu_src_b, result_src, alu_control, illegal_instr};
    endfunction

    function automatic logic [17:0] mk(bit req, bit wr, bit adr, bit irw, bit pcw, bit rgw,
                                       logic [1:0] imm, logic [1:0] sa, logic [1:0] sb,
                                       logic [1:0] res, logic [2:0] alu, bit ill);
        return {req, wr, adr, irw, pcw, rgw, imm, sa, sb, res, alu, ill};
    endfunction

    function automatic logic [2:0] expAlu(logic [2:0] f3, bit isR, bit f7);
        case (f3)
            3'b000:  return (isR && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            default: return 3'b010;
        endcase
    endfunction

    function automatic bit aluF3Ok(logic [2:0] f3);
        return f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7;
    endfunction

    function automatic void push(bit rdy, bit z, logic [17:0] e, string t);
        step_t s;
        s.ready = rdy; s.zro = z; s.exp = e; s.tag = t;
        stepQ.push_back(s);
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction from the fetch onward.
    function automatic void buildSeq(logic [31:0] instr, int wF, int wM, bit z, int trapLen);
        logic [6:0] o  = instr[6:0];
        logic [2:0] f3 = instr[14:12];
        bit         f7 = instr[30];
        bit         trap = 0;
        for (int i = 0; i < wF; i++)
            push(0, 1'($urandom), mk(1,0,0,0,0,0, 2'b00,2'b00,2'b10,2'b10,3'b000,0), "fetch_wait");
        push(1, 1'($urandom), mk(1,0,0,1,1,0, 2'b00,2'b00,2'b10,2'b10,3'b000,0), "fetch_done");
        push(1'($urandom), 1'($urandom), mk(0,0,0,0,0,0, 2'b10,2'b01,2'b01,2'b00,3'b000,0), "decode");
        if (o == 7'b0000011) begin
            push(1'($urandom), 1'($urandom), mk(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,3'b000,0), "lw_memadr");
            for (int i = 0; i < wM; i++)
                push(0, 1'($urandom), mk(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,3'b000,0), "memread_wait");
            push(1, 1'($urandom), mk(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,3'b000,0), "memread_done");
            push(1'($urandom), 1'($urandom), mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b01,3'b000,0), "memwb");
        end else if (o == 7'b0100011) begin
            push(1'($urandom), 1'($urandom), mk(0,0,0,0,0,0, 2'b01,2'b10,2'b01,2'b00,3'b000,0), "sw_memadr");
            for (int i = 0; i < wM; i++)
                push(0, 1'($urandom), mk(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,3'b000,0), "memwrite_wait");
            push(1, 1'($urandom), mk(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,3'b000,0), "memwrite_done");
        end else if (o == 7'b0110011 && aluF3Ok(f3)) begin
            push(1'($urandom), 1'($urandom), mk(0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b00,expAlu(f3,1,f7),0), "execr");
            push(1'($urandom), 1'($urandom), mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,3'b000,0), "aluwb");
        end else if (o == 7'b0010011 && aluF3Ok(f3)) begin
            push(1'($urandom), 1'($urandom), mk(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,expAlu(f3,0,f7),0), "execi");
            push(1'($urandom), 1'($urandom), mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,3'b000,0), "aluwb");
        end else if (o == 7'b1100011 && f3 == 3'd0) begin
            push(1'($urandom), z, mk(0,0,0,0,z,0, 2'b00,2'b10,2'b00,2'b00,3'b001,0), "beq");
        end else begin
            trap = 1;
        end
        if (trap)
            for (int i = 0; i < trapLen; i++)
                push(1'($urandom), 1'($urandom), mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,3'b000,1), "trap");
    endfunction

    task automatic runSteps(input int maxSteps);
        int n = 0;
        while (stepQ.size() > 0 && n < maxSteps) begin
            step_t s = stepQ.pop_front();
            @(negedge clk);
            mem_ready = s.ready;
            zero = s.zro;
            #1;
            checks++;
            if (observed() !== s.exp) begin
                failures++;
                $display("FAIL %s: got %h expected %h", s.tag, observed(), s.exp);
            end
            n++;
        end
        stepQ.delete();
    endtask

    task automatic runInstr(input logic [31:0] instr, input int wF, input int wM, input bit z,
                            input int maxSteps = 1000);
        op = instr[6:0];
        funct3 = instr[14:12];
        funct7b5 = instr[30];
        buildSeq(instr, wF, wM, z, 20);
        runSteps(maxSteps);
    endtask

    task automatic doReset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (observed() !== 18'd0) begin
            failures++;
            $display("FAIL reset_assert: got %h expected %h", observed(), 18'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (observed() !== 18'd0) begin
            failures++;
            $display("FAIL reset_idle: got %h expected %h", observed(), 18'd0);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (observed() !== 18'd0) begin
            failures++;
            $display("FAIL reset_power_on: got %h expected %h", observed(), 18'd0);
        end
        doReset();
    endtask

    task automatic test_lw();
        runInstr(32'h0000A083, 2, 2, 0);
    endtask

    task automatic test_sw();
        runInstr(32'h0020A023, 0, 0, 0);
    endtask

    task automatic test_rtype();
        runInstr(32'h40208033, 0, 0, 0);
        runInstr(32'h00208033, 1, 0, 0);
        runInstr(32'h0020E033, 0, 0, 0);
        runInstr(32'h0020A033, 0, 0, 0);
        runInstr(32'h0020F033, 0, 0, 0);
    endtask

    task automatic test_itype();
        runInstr(32'h40108093, 0, 0, 0);
        runInstr(32'h0010A093, 0, 0, 0);
    endtask

    task automatic test_beq();
        runInstr(32'h00208063, 0, 0, 1);
        runInstr(32'h00208063, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            logic [31:0] instr = $urandom;
            logic [2:0]  f3l[4] = '{3'd0, 3'd2, 3'd6, 3'd7};
            case ($urandom_range(0, 4))
                0: instr[6:0] = 7'b0000011;
                1: instr[6:0] = 7'b0100011;
                2: begin instr[6:0] = 7'b0110011; instr[14:12] = f3l[$urandom_range(0, 3)]; end
                3: begin instr[6:0] = 7'b0010011; instr[14:12] = f3l[$urandom_range(0, 3)]; end
                default: begin instr[6:0] = 7'b1100011; instr[14:12] = 3'd0; end
            endcase
            runInstr(instr, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        end
    endtask

    task automatic test_trap();
        runInstr(32'h0000007F, 1, 0, 0);
        doReset();
        runInstr(32'h00209033, 0, 0, 0);
        doReset();
        checks++;
        if (illegal_instr !== 1'b0) begin
            failures++;
            $display("FAIL trap_cleared: got %b expected 0", illegal_instr);
        end
    endtask

    task automatic test_reset_mid_access();
        runInstr(32'h0000A083, 0, 6, 0, 5);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || observed() !== 18'd0) begin
            failures++;
            $display("FAIL reset_mid_memread: got %h expected %h", observed(), 18'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        runInstr(32'h00208033, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_itype();
        test_beq();
        test_random();
        test_trap();
        test_reset_mid_access();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
